// File: rtl/fc_psum_accum.sv
// fc_psum_accum: accumulates per-neuron psum tiles from the PE array, adds bias,
// requantises (rounding arithmetic right shift, optional ReLU, int8 saturation)
// and queues int8 results in a small valid/ready output FIFO.
module fc_psum_accum #(
  parameter int PSUM_W     = 24,
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_TILES  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [$clog2(MAX_TILES):0]   cfg_tiles_i,
  input  logic [15:0]                  cfg_neurons_i,
  input  logic [4:0]                   cfg_shift_i,
  input  logic                         cfg_relu_i,
  input  logic [ACC_W-1:0]             bias_i,
  input  logic                         psum_valid_i,
  input  logic [PSUM_W-1:0]            psum_i,
  output logic                         psum_ready_o,
  output logic                         out_valid_o,
  output logic [7:0]                   out_data_o,
  input  logic                         out_ready_i,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int TW = $clog2(MAX_TILES) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]        DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-128);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_POST, S_PUSH} state_t;

  state_t                       r_state, w_next;
  logic [ACC_W-1:0]             r_acc, r_bias;
  logic [TW-1:0]                r_tiles, r_tile_cnt;
  logic [15:0]                  r_neurons, r_neuron_cnt;
  logic [4:0]                   r_shift;
  logic                         r_relu;
  logic [7:0]                   r_res;
  logic [FIFO_DEPTH-1:0][7:0]   r_mem;
  logic [PW-1:0]                r_wptr, r_rptr;
  logic [CW-1:0]                r_count;

  logic                         w_accept, w_last_tile, w_last_neuron, w_push, w_pop;
  logic [ACC_W-1:0]             w_psum_ext;
  logic signed [ACC_W:0]        w_round, w_sum, w_shr;
  logic [7:0]                   w_res;

  assign w_accept      = psum_valid_i && (r_state == S_ACC);
  assign w_last_tile   = (r_tile_cnt == r_tiles - TW'(1));
  assign w_last_neuron = (r_neuron_cnt == r_neurons - 16'd1);
  // Full test uses the pre-pop count: a pop this cycle does not free a slot until next cycle.
  assign w_push        = (r_state == S_PUSH) && (r_count != DEPTH_C);
  assign w_pop         = out_valid_o && out_ready_i;
  assign w_psum_ext    = {{(ACC_W-PSUM_W){psum_i[PSUM_W-1]}}, psum_i};

  // Requant runs one bit wider than the accumulator so the rounding add cannot wrap.
  assign w_round = (r_shift == 5'd0) ? '0 : ((ACC_W+1)'(1) << (r_shift - 5'd1));
  assign w_sum   = $signed({r_acc[ACC_W-1], r_acc}) + w_round;
  assign w_shr   = w_sum >>> r_shift;

  // ReLU then int8 saturation of the shifted value.
  always_comb begin
    w_res = w_shr[7:0];
    if (r_relu && w_shr[ACC_W])  w_res = 8'h00;
    else if (w_shr > SAT_MAX)    w_res = 8'h7F;
    else if (w_shr < SAT_MIN)    w_res = 8'h80;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    w_next       = r_state;
    psum_ready_o = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) w_next = S_ACC;
      end
      S_ACC: begin
        psum_ready_o = 1'b1;
        if (w_accept && w_last_tile) w_next = S_POST;
      end
      S_POST: w_next = S_PUSH;
      S_PUSH: begin
        if (w_push) begin
          if (w_last_neuron) begin
            done_o = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_next = S_ACC;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Job config latch, accumulator, tile/neuron counters and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_bias       <= '0;
      r_tiles      <= TW'(1);
      r_tile_cnt   <= '0;
      r_neurons    <= 16'd1;
      r_neuron_cnt <= '0;
      r_shift      <= '0;
      r_relu       <= 1'b0;
      r_res        <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) begin
          r_tiles      <= (cfg_tiles_i == '0) ? TW'(1) : cfg_tiles_i;
          r_neurons    <= (cfg_neurons_i == 16'd0) ? 16'd1 : cfg_neurons_i;
          r_shift      <= cfg_shift_i;
          r_relu       <= cfg_relu_i;
          r_bias       <= bias_i;
          r_acc        <= bias_i;
          r_tile_cnt   <= '0;
          r_neuron_cnt <= '0;
        end
        S_ACC: if (w_accept) begin
          r_acc      <= r_acc + w_psum_ext;
          r_tile_cnt <= r_tile_cnt + TW'(1);
        end
        S_POST: r_res <= w_res;
        S_PUSH: if (w_push) begin
          r_neuron_cnt <= r_neuron_cnt + 16'd1;
          if (!w_last_neuron) begin
            r_acc      <= r_bias;
            r_tile_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful under the count, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_res;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid_o = (r_count != '0);
  assign out_data_o  = out_valid_o ? r_mem[r_rptr] : 8'h00;

endmodule

// File: tb/tb_fc_psum_accum.sv
// Directed testbench for fc_psum_accum with hand-computed expected results.
module tb_fc_psum_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [4:0]  cfg_tiles_i;
  logic [15:0] cfg_neurons_i;
  logic [4:0]  cfg_shift_i;
  logic        cfg_relu_i;
  logic [31:0] bias_i;
  logic        psum_valid_i;
  logic [23:0] psum_i;
  logic        psum_ready_o;
  logic        out_valid_o;
  logic [7:0]  out_data_o;
  logic        out_ready_i;
  logic        busy_o;
  logic        done_o;

  int total = 0;
  int bad   = 0;

  fc_psum_accum #(.PSUM_W(24), .ACC_W(32), .FIFO_DEPTH(4), .MAX_TILES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .cfg_tiles_i(cfg_tiles_i),
    .cfg_neurons_i(cfg_neurons_i), .cfg_shift_i(cfg_shift_i), .cfg_relu_i(cfg_relu_i),
    .bias_i(bias_i), .psum_valid_i(psum_valid_i), .psum_i(psum_i),
    .psum_ready_o(psum_ready_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int tiles, input int neurons, input int shift,
                           input int relu, input int bias);
    cfg_tiles_i   = 5'(tiles);
    cfg_neurons_i = 16'(neurons);
    cfg_shift_i   = 5'(shift);
    cfg_relu_i    = 1'(relu);
    bias_i        = 32'(bias);
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
  endtask

  task automatic send_psum(input int v);
    int n = 0;
    psum_valid_i = 1'b0;
    while (!psum_ready_o && n < 100) begin tick(); n++; end
    psum_valid_i = 1'b1;
    psum_i       = 24'(v);
    tick();
    psum_valid_i = 1'b0;
  endtask

  task automatic get_result(output logic [7:0] d, output bit ok);
    int n = 0;
    out_ready_i = 1'b1;
    while (!out_valid_o && n < 100) begin tick(); n++; end
    ok = out_valid_o;
    d  = out_data_o;
    if (ok) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; cfg_tiles_i = '0; cfg_neurons_i = '0; cfg_shift_i = '0;
    cfg_relu_i = 1'b0; bias_i = '0; psum_valid_i = 1'b0; psum_i = '0; out_ready_i = 1'b0;
    tick(); tick();
    total++; if (psum_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", psum_ready_o); end
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
    total++; if (out_data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data_o); end
    total++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b exp=00", busy_o, done_o); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int dn = 0;
    out_ready_i = 1'b1;
    start_job(1, 1, 0, 0, 0);
    total++; if (psum_ready_o !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", psum_ready_o); end
    psum_valid_i = 1'b1; psum_i = 24'd100;
    tick();                                   // accept edge
    psum_valid_i = 1'b0;
    dn += int'(done_o);
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL single_post_valid got=%b exp=0", out_valid_o); end
    tick();                                   // into PUSH
    dn += int'(done_o);
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL single_done got=%b exp=1", done_o); end
    tick();                                   // write edge
    dn += int'(done_o);
    total++; if (out_valid_o !== 1'b1 || out_data_o !== 8'd100) begin bad++; $display("FAIL single_out got=%b/%0d exp=1/100", out_valid_o, $signed(out_data_o)); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy_o); end
    tick();
    dn += int'(done_o);
    total++; if (dn != 1) begin bad++; $display("FAIL single_done_count got=%0d exp=1", dn); end
    total++; if (out_valid_o !== 1'b0 || out_data_o !== 8'h00) begin bad++; $display("FAIL single_empty got=%b/%h exp=0/00", out_valid_o, out_data_o); end
  endtask

  task automatic test_multi_tile();
    logic [7:0] d; bit ok;
    start_job(3, 1, 5, 0, 12);
    send_psum(1000); send_psum(2000); send_psum(-500);
    get_result(d, ok);
    total++; if (!ok || d !== 8'd79) begin bad++; $display("FAIL multi_tile got=%0d exp=79 ok=%0d", $signed(d), ok); end
  endtask

  task automatic test_saturation();
    logic [7:0] d; bit ok;
    start_job(1, 1, 1, 0, 0); send_psum(-300); get_result(d, ok);
    total++; if (!ok || d !== 8'h80) begin bad++; $display("FAIL sat_neg got=%0d exp=-128", $signed(d)); end
    start_job(1, 1, 1, 1, 0); send_psum(-300); get_result(d, ok);
    total++; if (!ok || d !== 8'h00) begin bad++; $display("FAIL relu got=%0d exp=0", $signed(d)); end
    start_job(1, 1, 0, 0, 0); send_psum(70000); get_result(d, ok);
    total++; if (!ok || d !== 8'h7F) begin bad++; $display("FAIL sat_pos got=%0d exp=127", $signed(d)); end
  endtask

  task automatic test_backpressure();
    int vals[6] = '{10, 20, 30, 40, 50, 60};
    logic [7:0] got[6];
    int sent = 0, ng = 0, dn = 0;
    out_ready_i = 1'b0;
    start_job(1, 6, 0, 0, 0);
    for (int cyc = 0; cyc < 80; cyc++) begin
      out_ready_i = (cyc >= 30);
      if (cyc == 29) begin
        total++; if (psum_ready_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL bp_stall got=ready%b busy%b exp=ready0 busy1", psum_ready_o, busy_o); end
        total++; if (sent != 5) begin bad++; $display("FAIL bp_sent got=%0d exp=5", sent); end
        total++; if (out_valid_o !== 1'b1 || out_data_o !== 8'd10) begin bad++; $display("FAIL bp_head got=%b/%0d exp=1/10", out_valid_o, out_data_o); end
      end
      if (psum_ready_o && sent < 6) begin
        psum_valid_i = 1'b1; psum_i = 24'(vals[sent]); sent++;
      end else begin
        psum_valid_i = 1'b0;
      end
      if (out_valid_o && out_ready_i) begin
        if (ng < 6) got[ng] = out_data_o;
        ng++;
      end
      if (done_o) dn++;
      tick();
    end
    psum_valid_i = 1'b0;
    total++; if (ng != 6) begin bad++; $display("FAIL bp_count got=%0d exp=6", ng); end
    for (int i = 0; i < 6 && i < ng; i++) begin
      total++; if (got[i] !== 8'(vals[i])) begin bad++; $display("FAIL bp_order[%0d] got=%0d exp=%0d", i, got[i], vals[i]); end
    end
    total++; if (dn != 1 || busy_o !== 1'b0) begin bad++; $display("FAIL bp_done got=%0d busy=%b exp=1 busy=0", dn, busy_o); end
  endtask

  task automatic test_start_ignored();
    logic [7:0] d; bit ok;
    out_ready_i = 1'b1;
    start_job(2, 1, 0, 0, 5);
    send_psum(7);
    start_job(1, 3, 3, 1, 1000);   // busy: must be ignored
    send_psum(8);
    get_result(d, ok);
    total++; if (!ok || d !== 8'd20) begin bad++; $display("FAIL start_ignored got=%0d exp=20", $signed(d)); end
    tick(); tick(); tick(); tick();
    total++; if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin bad++; $display("FAIL start_ignored_idle got=busy%b valid%b exp=00", busy_o, out_valid_o); end
  endtask

  task automatic test_reset_midjob();
    logic [7:0] d; bit ok;
    out_ready_i = 1'b0;
    start_job(1, 1, 0, 0, 0); send_psum(33);
    tick(); tick(); tick();
    total++; if (out_valid_o !== 1'b1 || out_data_o !== 8'd33) begin bad++; $display("FAIL rst_prefill got=%b/%0d exp=1/33", out_valid_o, out_data_o); end
    start_job(4, 1, 0, 0, 0); send_psum(50);
    total++; if (busy_o !== 1'b1 || psum_ready_o !== 1'b1) begin bad++; $display("FAIL rst_in_acc got=busy%b ready%b exp=11", busy_o, psum_ready_o); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({psum_ready_o, out_valid_o, busy_o, done_o} !== 4'b0000 || out_data_o !== 8'h00) begin
      bad++; $display("FAIL rst_async got=r%b v%b b%b d%b data%h exp=all 0", psum_ready_o, out_valid_o, busy_o, done_o, out_data_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
    out_ready_i = 1'b1;
    start_job(2, 1, 2, 0, -3);
    send_psum(9); send_psum(6);
    get_result(d, ok);
    total++; if (!ok || d !== 8'd3) begin bad++; $display("FAIL rst_fresh got=%0d exp=3", $signed(d)); end
  endtask

  task automatic test_valid_gating();
    logic [7:0] d; bit ok;
    out_ready_i  = 1'b0;
    psum_valid_i = 1'b1; psum_i = 24'd999;
    tick(); tick(); tick();
    start_job(2, 2, 0, 0, 0);                 // valid still high through IDLE
    psum_valid_i = 1'b0; tick(); tick();      // gap
    psum_valid_i = 1'b1; psum_i = 24'd4; tick();
    psum_valid_i = 1'b0; tick();              // gap
    psum_valid_i = 1'b1; psum_i = 24'd6; tick();
    psum_i = 24'd999;                         // held high into POST/PUSH
    total++; if (psum_ready_o !== 1'b0) begin bad++; $display("FAIL gate_post got=%b exp=0", psum_ready_o); end
    tick();
    total++; if (psum_ready_o !== 1'b0) begin bad++; $display("FAIL gate_push got=%b exp=0", psum_ready_o); end
    tick();
    total++; if (psum_ready_o !== 1'b1) begin bad++; $display("FAIL gate_acc2 got=%b exp=1", psum_ready_o); end
    psum_i = 24'(-2); tick();
    psum_i = 24'd3;   tick();
    psum_i = 24'd999; tick(); tick(); tick(); tick();
    psum_valid_i = 1'b0;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL gate_busy got=%b exp=0", busy_o); end
    get_result(d, ok);
    total++; if (!ok || d !== 8'd10) begin bad++; $display("FAIL gate_n0 got=%0d exp=10", $signed(d)); end
    get_result(d, ok);
    total++; if (!ok || d !== 8'd1) begin bad++; $display("FAIL gate_n1 got=%0d exp=1", $signed(d)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_tile();
    test_saturation();
    test_backpressure();
    test_start_ignored();
    test_reset_midjob();
    test_valid_gating();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
